// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC bus-cycle scheduler: FSM states,
// time-register offsets, default register map and state-sequencing helpers.
package rtc_pkg;

    typedef enum logic [3:0] {
        INIT0_ISSUE, INIT0_ACCEPT, INIT0_DONE,
        INIT1_ISSUE, INIT1_ACCEPT, INIT1_DONE,
        IDLE,
        RD_ISSUE, RD_ACCEPT, RD_DONE, PUBLISH,
        WR_ISSUE, WR_ACCEPT, WR_DONE
    } sched_state_e;

    localparam logic [2:0] REG_SEC   = 3'd0;
    localparam logic [2:0] REG_MIN   = 3'd1;
    localparam logic [2:0] REG_HOUR  = 3'd2;
    localparam logic [2:0] REG_DAY   = 3'd3;
    localparam logic [2:0] REG_MONTH = 3'd4;
    localparam logic [2:0] REG_YEAR  = 3'd5;
    localparam int unsigned NUM_TIME_REGS = 6;

    localparam int unsigned DEF_REFRESH_CYCLES = 100000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 64;
    localparam logic [7:0]  DEF_TIME_BASE_ADDR = 8'h21;
    localparam logic [7:0]  DEF_INIT_ADDR0     = 8'h02;
    localparam logic [7:0]  DEF_INIT_DATA0     = 8'h10;
    localparam logic [7:0]  DEF_INIT_ADDR1     = 8'h00;
    localparam logic [7:0]  DEF_INIT_DATA1     = 8'h00;

    function automatic logic [7:0] time_reg_addr(input logic [7:0] base, input logic [2:0] idx);
        return base + {5'b00000, idx};
    endfunction

    function automatic sched_state_e accept_of(input sched_state_e s);
        case (s)
            INIT0_ISSUE: return INIT0_ACCEPT;
            INIT1_ISSUE: return INIT1_ACCEPT;
            RD_ISSUE:    return RD_ACCEPT;
            WR_ISSUE:    return WR_ACCEPT;
            default:     return IDLE;
        endcase
    endfunction

    function automatic sched_state_e done_of(input sched_state_e s);
        case (s)
            INIT0_ACCEPT: return INIT0_DONE;
            INIT1_ACCEPT: return INIT1_DONE;
            RD_ACCEPT:    return RD_DONE;
            WR_ACCEPT:    return WR_DONE;
            default:      return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rtc_scheduler_if.sv
// Handshake between the scheduler (master) and the multiplexed RTC bus-cycle engine (slave).
interface rtc_scheduler_if;
    logic       bus_start;
    logic       bus_write;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_busy;
    logic [7:0] bus_rdata;
    logic       bus_rdata_valid;

    modport master (
        output bus_start, bus_write, bus_addr, bus_wdata,
        input  bus_busy, bus_rdata, bus_rdata_valid
    );

    modport slave (
        input  bus_start, bus_write, bus_addr, bus_wdata,
        output bus_busy, bus_rdata, bus_rdata_valid
    );
endinterface

// File: rtl/rtc_refresh_timer.sv
// Free-running refresh counter; raises a sticky snapshot request on every wrap
// or on force_set, dropped by clear once the snapshot is published.
module rtc_refresh_timer
    import rtc_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic force_set,
    output logic refresh_pending
);

    localparam int unsigned CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pending_q, pending_d;
    logic          wrap_s;

    // Next count and request flag; a new request outranks a coincident clear.
    always_comb begin
        wrap_s = (cnt_q == CNT_LAST);
        if (wrap_s) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
        if (wrap_s || force_set) begin
            pending_d = 1'b1;
        end else if (clear) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Counter and request flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= {CW{1'b0}};
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign refresh_pending = pending_q;

endmodule

// File: rtl/rtc_scheduler.sv
// Shares one RTC bus-cycle engine between post-reset init writes, periodic
// six-register time snapshots and user time-set writes.
module rtc_scheduler
    import rtc_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = DEF_REFRESH_CYCLES,
    parameter logic [7:0]  TIME_BASE_ADDR = DEF_TIME_BASE_ADDR,
    parameter logic [7:0]  INIT_ADDR0     = DEF_INIT_ADDR0,
    parameter logic [7:0]  INIT_DATA0     = DEF_INIT_DATA0,
    parameter logic [7:0]  INIT_ADDR1     = DEF_INIT_ADDR1,
    parameter logic [7:0]  INIT_DATA1     = DEF_INIT_DATA1,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wr_req,
    input  logic [7:0]      wr_addr,
    input  logic [7:0]      wr_data,
    output logic            wr_ack,
    rtc_scheduler_if.master bus,
    output logic [7:0]      time_sec,
    output logic [7:0]      time_min,
    output logic [7:0]      time_hour,
    output logic [7:0]      time_day,
    output logic [7:0]      time_month,
    output logic [7:0]      time_year,
    output logic            time_valid,
    output logic            init_done,
    output logic            timeout_err,
    output logic            sched_busy
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] LAST_IDX = 3'(NUM_TIME_REGS - 1);

    sched_state_e  state_q, state_d;
    logic          bus_start_q, bus_start_d, bus_write_q, bus_write_d;
    logic [7:0]    bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [2:0]    rd_idx_q, rd_idx_d;
    logic          rdv_prev_q, rdv_prev_d;
    logic [7:0]    shadow_q [NUM_TIME_REGS];
    logic [7:0]    shadow_d [NUM_TIME_REGS];
    logic [7:0]    time_q [NUM_TIME_REGS];
    logic [7:0]    time_d [NUM_TIME_REGS];
    logic          time_valid_q, time_valid_d, wr_ack_q, wr_ack_d;
    logic          init_done_q, init_done_d, timeout_err_q, timeout_err_d;
    logic          sched_busy_q, sched_busy_d;
    logic          iss_write_s;
    logic [7:0]    iss_addr_s, iss_data_s;
    logic          pend_clear_s, pend_set_s, refresh_pending_s;

    rtc_refresh_timer #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_refresh_timer (
        .clk             (clk),
        .reset_n         (reset_n),
        .clear           (pend_clear_s),
        .force_set       (pend_set_s),
        .refresh_pending (refresh_pending_s)
    );

    // Engine command for the transaction the current ISSUE state launches.
    always_comb begin
        iss_write_s = 1'b0;
        iss_addr_s  = time_reg_addr(TIME_BASE_ADDR, rd_idx_q);
        iss_data_s  = 8'h00;
        case (state_q)
            INIT0_ISSUE: begin iss_write_s = 1'b1; iss_addr_s = INIT_ADDR0; iss_data_s = INIT_DATA0; end
            INIT1_ISSUE: begin iss_write_s = 1'b1; iss_addr_s = INIT_ADDR1; iss_data_s = INIT_DATA1; end
            WR_ISSUE:    begin iss_write_s = 1'b1; iss_addr_s = wr_addr;    iss_data_s = wr_data;    end
            default:     begin iss_write_s = 1'b0; iss_addr_s = time_reg_addr(TIME_BASE_ADDR, rd_idx_q); iss_data_s = 8'h00; end
        endcase
    end

    // Sequencer next-state: issue/accept/done micro-sequence plus arbitration.
    always_comb begin
        state_d       = state_q;
        bus_start_d   = 1'b0;
        bus_write_d   = bus_write_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        tmo_cnt_d     = tmo_cnt_q;
        rd_idx_d      = rd_idx_q;
        rdv_prev_d    = bus.bus_rdata_valid;
        shadow_d      = shadow_q;
        time_d        = time_q;
        time_valid_d  = 1'b0;
        wr_ack_d      = 1'b0;
        init_done_d   = init_done_q;
        timeout_err_d = timeout_err_q;
        pend_clear_s  = 1'b0;
        pend_set_s    = 1'b0;

        // Only the first cycle of a (possibly long) data strobe is captured.
        if ((state_q == RD_ACCEPT || state_q == RD_DONE) && bus.bus_rdata_valid && !rdv_prev_q) begin
            shadow_d[rd_idx_q] = bus.bus_rdata;
        end else begin
            shadow_d = shadow_q;
        end

        case (state_q)
            INIT0_ISSUE, INIT1_ISSUE, RD_ISSUE, WR_ISSUE: begin
                if (state_q == WR_ISSUE && !wr_req) begin
                    state_d = IDLE;
                end else if (!bus.bus_busy) begin
                    bus_start_d = 1'b1;
                    bus_write_d = iss_write_s;
                    bus_addr_d  = iss_addr_s;
                    bus_wdata_d = iss_data_s;
                    tmo_cnt_d   = {TW{1'b0}};
                    state_d     = accept_of(state_q);
                end else begin
                    state_d = state_q;
                end
            end
            INIT0_ACCEPT, INIT1_ACCEPT, RD_ACCEPT, WR_ACCEPT: begin
                if (bus.bus_busy) begin
                    state_d = done_of(state_q);
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Abandon; pending refresh or held wr_req is retried from IDLE.
                    timeout_err_d = 1'b1;
                    rd_idx_d      = 3'd0;
                    state_d       = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            INIT0_DONE: begin
                if (!bus.bus_busy) state_d = INIT1_ISSUE;
                else               state_d = state_q;
            end
            INIT1_DONE: begin
                if (!bus.bus_busy) begin
                    init_done_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            RD_DONE: begin
                if (!bus.bus_busy && rd_idx_q == LAST_IDX) begin
                    rd_idx_d = 3'd0;
                    state_d  = PUBLISH;
                end else if (!bus.bus_busy) begin
                    rd_idx_d = rd_idx_q + 3'd1;
                    state_d  = RD_ISSUE;
                end else begin
                    state_d = state_q;
                end
            end
            WR_DONE: begin
                if (!bus.bus_busy) begin
                    wr_ack_d   = 1'b1;
                    pend_set_s = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            PUBLISH: begin
                time_d       = shadow_q;
                time_valid_d = 1'b1;
                pend_clear_s = 1'b1;
                state_d      = IDLE;
            end
            IDLE: begin
                // wr_ack_q masks the still-held request of the write just acknowledged.
                if (wr_req && !wr_ack_q)     state_d = WR_ISSUE;
                else if (refresh_pending_s)  state_d = RD_ISSUE;
                else                         state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        sched_busy_d = (state_d != IDLE);
    end

    // All sequencer state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= INIT0_ISSUE;
            bus_start_q   <= 1'b0;
            bus_write_q   <= 1'b0;
            bus_addr_q    <= 8'h00;
            bus_wdata_q   <= 8'h00;
            tmo_cnt_q     <= {TW{1'b0}};
            rd_idx_q      <= 3'd0;
            rdv_prev_q    <= 1'b0;
            shadow_q      <= '{default: 8'h00};
            time_q        <= '{default: 8'h00};
            time_valid_q  <= 1'b0;
            wr_ack_q      <= 1'b0;
            init_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            sched_busy_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus_start_q   <= bus_start_d;
            bus_write_q   <= bus_write_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            tmo_cnt_q     <= tmo_cnt_d;
            rd_idx_q      <= rd_idx_d;
            rdv_prev_q    <= rdv_prev_d;
            shadow_q      <= shadow_d;
            time_q        <= time_d;
            time_valid_q  <= time_valid_d;
            wr_ack_q      <= wr_ack_d;
            init_done_q   <= init_done_d;
            timeout_err_q <= timeout_err_d;
            sched_busy_q  <= sched_busy_d;
        end
    end

    assign bus.bus_start = bus_start_q;
    assign bus.bus_write = bus_write_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign wr_ack        = wr_ack_q;
    assign time_sec      = time_q[REG_SEC];
    assign time_min      = time_q[REG_MIN];
    assign time_hour     = time_q[REG_HOUR];
    assign time_day      = time_q[REG_DAY];
    assign time_month    = time_q[REG_MONTH];
    assign time_year     = time_q[REG_YEAR];
    assign time_valid    = time_valid_q;
    assign init_done     = init_done_q;
    assign timeout_err   = timeout_err_q;
    assign sched_busy    = sched_busy_q;

endmodule

// File: tb/tb_rtc_scheduler.sv
// Directed bench for rtc_scheduler with a behavioural RTC engine
// (busy 1 cycle after start, 30 cycles long, data strobe in its last 3 cycles).
module tb_rtc_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_req;
    logic [7:0] wr_addr, wr_data;
    logic       wr_ack;
    logic [7:0] time_sec, time_min, time_hour, time_day, time_month, time_year;
    logic       time_valid, init_done, timeout_err, sched_busy;

    rtc_scheduler_if ifc ();

    rtc_scheduler #(.REFRESH_CYCLES(200)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .bus(ifc),
        .time_sec(time_sec), .time_min(time_min), .time_hour(time_hour),
        .time_day(time_day), .time_month(time_month), .time_year(time_year),
        .time_valid(time_valid), .init_done(init_done),
        .timeout_err(timeout_err), .sched_busy(sched_busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    int tv_cnt  = 0;
    logic dead = 1'b0;
    logic [7:0]  mem [256];
    logic [16:0] log_q [$];
    logic [70:0] all_outs;

    assign all_outs = {wr_ack, ifc.bus_start, ifc.bus_write, ifc.bus_addr, ifc.bus_wdata,
                       time_sec, time_min, time_hour, time_day, time_month, time_year,
                       time_valid, init_done, timeout_err, sched_busy};

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: logs every start, then answers it unless dead.
    initial begin
        logic [7:0] a, d;
        logic       w;
        ifc.bus_busy = 1'b0; ifc.bus_rdata_valid = 1'b0; ifc.bus_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && ifc.bus_start === 1'b1) begin
                log_q.push_back({ifc.bus_write, ifc.bus_addr, ifc.bus_wdata});
                start_cyc = cyc;
                if (!dead) begin
                    a = ifc.bus_addr; w = ifc.bus_write; d = ifc.bus_wdata;
                    for (int i = 0; i < 30; i++) begin
                        ifc.bus_busy = 1'b1;
                        ifc.bus_rdata_valid = (i >= 27);
                        ifc.bus_rdata = w ? 8'h00 : mem[a];
                        @(negedge clk);
                        if (i == 0 && reset_n === 1'b1) chk("start_one_cycle", ifc.bus_start, 1'b0);
                    end
                    ifc.bus_busy = 1'b0; ifc.bus_rdata_valid = 1'b0;
                    if (w) mem[a] = d;
                    done_cyc = cyc;
                end
            end
        end
    end

    // Pulse-shape monitor for time_valid, wr_ack and init_done latency.
    initial begin
        logic tv_prev, ack_prev, id_prev;
        tv_prev = 1'b0; ack_prev = 1'b0; id_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (time_valid === 1'b1) begin
                tv_cnt++;
                chk("time_valid_single", tv_prev, 1'b0);
            end
            if (wr_ack === 1'b1) chk("wr_ack_single", ack_prev, 1'b0);
            if (init_done === 1'b1 && id_prev === 1'b0) chk("init_done_latency", cyc, done_cyc + 1);
            tv_prev = time_valid; ack_prev = wr_ack; id_prev = init_done;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0, tv_snap, k;
        logic raised;
        logic [8:0] e;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h21] = 8'h45; mem[8'h22] = 8'h30; mem[8'h23] = 8'h12;
        mem[8'h24] = 8'h07; mem[8'h25] = 8'h04; mem[8'h26] = 8'h17;
        reset_n = 1'b0; wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs, 71'd0);
        reset_n = 1'b1;

        // Init writes.
        for (k = 0; k < 300 && init_done !== 1'b1; k++) @(negedge clk);
        chk("init_done", init_done, 1'b1);
        chk("init_count", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            chk("init_wr0", log_q[0], {1'b1, 8'h02, 8'h10});
            chk("init_wr1", log_q[1], {1'b1, 8'h00, 8'h00});
        end

        // First snapshot, with a user write raised during the burst.
        raised = 1'b0;
        for (k = 0; k < 800 && time_valid !== 1'b1; k++) begin
            @(negedge clk);
            if (!raised && log_q.size() >= 5) begin
                wr_req = 1'b1; wr_addr = 8'h22; wr_data = 8'h59; raised = 1'b1;
            end
        end
        chk("snap1_seen", time_valid, 1'b1);
        chk("no_write_in_burst", log_q.size(), 8);
        for (int i = 0; i < 6; i++) begin
            e = {1'b0, 8'h21 + i[7:0]};
            if (log_q.size() > 2 + i) chk("rd_addr", log_q[2 + i][16:8], e);
        end
        chk("sec",   time_sec,   8'h45);
        chk("min",   time_min,   8'h30);
        chk("hour",  time_hour,  8'h12);
        chk("day",   time_day,   8'h07);
        chk("month", time_month, 8'h04);
        chk("year",  time_year,  8'h17);

        for (k = 0; k < 200 && wr_ack !== 1'b1; k++) @(negedge clk);
        chk("wr_ack_seen", wr_ack, 1'b1);
        wr_req = 1'b0;
        if (log_q.size() > 8) chk("user_write", log_q[8], {1'b1, 8'h22, 8'h59});
        else chk("user_write_count", log_q.size(), 9);
        @(negedge clk);
        for (k = 0; k < 400 && time_valid !== 1'b1; k++) @(negedge clk);
        chk("snap2_seen", time_valid, 1'b1);
        if (log_q.size() > 9) chk("reread_first", log_q[9][16:8], {1'b0, 8'h21});
        chk("min_after_write", time_min, 8'h59);
        chk("sec_after_write", time_sec, 8'h45);

        // Dead engine: read times out while a write is waiting, write goes first.
        @(negedge clk);
        dead = 1'b1;
        n0 = log_q.size();
        for (k = 0; k < 600 && log_q.size() == n0; k++) @(negedge clk);
        dead = 1'b0;
        chk("dead_read_issued", log_q.size(), n0 + 1);
        if (log_q.size() > n0) chk("dead_read_addr", log_q[n0][16:8], {1'b0, 8'h21});
        tv_snap = tv_cnt;
        wr_req = 1'b1; wr_addr = 8'h23; wr_data = 8'h08;
        for (k = 0; k < 100 && timeout_err !== 1'b1; k++) @(negedge clk);
        chk("timeout_err", timeout_err, 1'b1);
        chk("timeout_latency", cyc - start_cyc, 64);
        chk("timeout_idle", sched_busy, 1'b0);
        chk("timeout_no_publish", tv_cnt, tv_snap);
        for (k = 0; k < 20 && log_q.size() < n0 + 2; k++) @(negedge clk);
        if (log_q.size() > n0 + 1) chk("write_before_read", log_q[n0 + 1], {1'b1, 8'h23, 8'h08});
        else chk("write_before_read_count", log_q.size(), n0 + 2);
        for (k = 0; k < 100 && wr_ack !== 1'b1; k++) @(negedge clk);
        chk("wr_ack2_seen", wr_ack, 1'b1);
        wr_req = 1'b0;
        chk("timeout_sticky", timeout_err, 1'b1);
        @(negedge clk);
        for (k = 0; k < 400 && time_valid !== 1'b1; k++) @(negedge clk);
        chk("snap3_seen", time_valid, 1'b1);
        chk("hour_after_write", time_hour, 8'h08);
        chk("min_kept", time_min, 8'h59);

        // Reset during the third read of a burst.
        @(negedge clk);
        n0 = log_q.size();
        for (k = 0; k < 600; k++) begin
            @(negedge clk);
            if (log_q.size() > n0 && log_q[log_q.size() - 1][16:8] == {1'b0, 8'h23}) break;
        end
        chk("third_read_seen", log_q[log_q.size() - 1][16:8], {1'b0, 8'h23});
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset_outputs", all_outs, 71'd0);
        repeat (3) @(negedge clk);
        chk("midreset_held", all_outs, 71'd0);
        n0 = log_q.size();
        reset_n = 1'b1;
        for (k = 0; k < 300 && init_done !== 1'b1; k++) @(negedge clk);
        chk("reinit_done", init_done, 1'b1);
        chk("reinit_count", log_q.size(), n0 + 2);
        if (log_q.size() >= n0 + 2) begin
            chk("reinit_wr0", log_q[n0],     {1'b1, 8'h02, 8'h10});
            chk("reinit_wr1", log_q[n0 + 1], {1'b1, 8'h00, 8'h00});
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
